fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipeline: owns the PC register, issues one instruction-memory

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction-memory request at a time and
// loads the IF/ID register; EX redirects kill the in-flight fetch and flush IF/ID.
module fetch_stage #(
  parameter int                PC_W     = 9,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic            imem_req_valid,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            IfId_Valid,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr
);

  typedef enum logic [1:0] {RST, REQ, WAIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;
  logic            kill_q, kill_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]     buf_q, buf_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;

  logic            ifid_wr;
  logic [31:0]     wr_instr;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] pc_inc;
  logic            unused_brpc;

  // Redirect targets are word aligned and truncated to the PC width.
  assign br_pc       = {BrPC[PC_W-1:2], 2'b00};
  assign pc_inc      = req_addr_q + PC_W'(4);
  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    kill_d      = kill_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    buf_d       = buf_q;
    ifid_wr     = 1'b0;
    wr_instr    = imem_rsp_data;

    unique case (state_q)
      RST: begin
        state_d     = REQ;
        req_valid_d = 1'b1;
        req_addr_d  = pc_q;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
          kill_d      = PcSel | pend_q;
          pend_d      = 1'b0;
          pc_d        = PcSel ? br_pc : (pend_q ? pend_pc_q : pc_inc);
        end else if (PcSel) begin
          // Address must stay stable until accepted; remember the redirect.
          pend_d    = 1'b1;
          pend_pc_d = br_pc;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || PcSel) begin
            kill_d      = 1'b0;
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = PcSel ? br_pc : pc_q;
            if (PcSel) pc_d = br_pc;
          end else if (!Stall) begin
            ifid_wr     = 1'b1;
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_addr_d  = pc_q;
          end else begin
            buf_d   = imem_rsp_data;
            state_d = HOLD;
          end
        end else if (PcSel) begin
          kill_d = 1'b1;
          pc_d   = br_pc;
        end
      end
      HOLD: begin
        if (PcSel) begin
          pc_d        = br_pc;
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_addr_d  = br_pc;
        end else if (!Stall) begin
          ifid_wr     = 1'b1;
          wr_instr    = buf_q;
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_addr_d  = pc_q;
        end
      end
      default: state_d = RST;
    endcase

    // IF/ID: redirect flushes, stall holds, otherwise a bubble unless written.
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (PcSel) begin
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      if (ifid_wr) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = req_addr_q;
        ifid_instr_d = wr_instr;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RST;
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      kill_q       <= 1'b0;
      pend_q       <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      kill_q       <= kill_d;
      pend_q       <= pend_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  // Pure data: only meaningful while pend_q is set or the FSM is in HOLD.
  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
    buf_q     <= buf_d;
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign IfId_Valid     = ifid_valid_q;
  assign IfId_PC        = ifid_pc_q;
  assign IfId_Instr     = ifid_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory responder plus a scoreboard of the
// instructions expected to reach IF/ID, with directed redirect/stall/reset cases.
module tb_fetch_stage;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            imem_req_valid;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            IfId_Valid;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int rsp_delay = 1;
  int last_acc = 0;
  logic [PC_W-1:0] rsp_addr;

  fetch_stage #(.PC_W(PC_W), .RESET_PC('0), .NOP(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .IfId_Valid(IfId_Valid),
    .IfId_PC(IfId_PC), .IfId_Instr(IfId_Instr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rsp_word(input logic [PC_W-1:0] a);
    return {23'd0, a} | 32'h0000_A000;
  endfunction

  task automatic push_exp(input logic [PC_W-1:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rsp_word(pc);
    sb_q.push_back(e);
  endtask

  // One clock edge: memory responder, then scoreboard compare on any IF/ID write.
  task automatic cycle();
    logic acc;
    logic [PC_W-1:0] a;
    logic st;
    acc = imem_req_valid && imem_req_ready && reset;
    a   = imem_req_addr;
    st  = Stall;
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rsp_word(rsp_addr);
      end
    end
    if (acc) begin
      rsp_addr = a;
      if (rsp_delay <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rsp_word(a);
      end else begin
        rsp_cnt = rsp_delay - 1;
      end
    end
    if (IfId_Valid && !st) begin
      if (sb_q.size() == 0) begin
        check("ifid_spurious", IfId_Valid, 32'd0);
      end else begin
        last_exp = sb_q.pop_front();
        check("ifid_pc", IfId_PC, last_exp.pc);
        check("ifid_instr", IfId_Instr, last_exp.instr);
      end
    end
  endtask

  task automatic wait_accept(input logic [PC_W-1:0] exp, input string tag);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_req_valid"}, imem_req_valid, 32'd1);
    check({tag, "_req_addr"}, imem_req_addr, exp);
    last_acc = cyc;
    cycle();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_drain"}, sb_q.size(), 32'd0);
  endtask

  // Accept exp with a slow response, then redirect to tgt while it is outstanding.
  task automatic redirect_in_wait(input logic [PC_W-1:0] exp, input logic [31:0] tgt,
                                  input string tag);
    rsp_delay = 3;
    wait_accept(exp, tag);
    PcSel = 1'b1;
    BrPC  = tgt;
    cycle();
    PcSel = 1'b0;
    check({tag, "_flush_valid"}, IfId_Valid, 32'd0);
    rsp_delay = 1;
  endtask

  initial begin
    int c0;
    reset          = 1'b0;
    Stall          = 1'b0;
    PcSel          = 1'b0;
    BrPC           = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    last_exp       = '0;

    // T1 reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    check("rst_ifid_valid", IfId_Valid, 32'd0);
    check("rst_ifid_pc", IfId_PC, 32'd0);
    check("rst_ifid_instr", IfId_Instr, 32'h0000_0013);
    reset = 1'b1;
    check("t1_first_req_valid", imem_req_valid, 32'd0);
    cycle();
    check("t1_req_valid", imem_req_valid, 32'd1);
    check("t1_req_addr", imem_req_addr, 32'd0);
    check("t1_ifid_valid", IfId_Valid, 32'd0);
    check("t1_ifid_instr", IfId_Instr, 32'h0000_0013);

    // T2 streaming
    push_exp(9'h000);
    push_exp(9'h004);
    wait_accept(9'h000, "t2_a0");
    c0 = last_acc;
    wait_accept(9'h004, "t2_a4");
    check("t2_spacing", last_acc - c0, 32'd2);

    // T3 redirect in WAIT while 0x8 is outstanding
    redirect_in_wait(9'h008, 32'h0000_0040, "t3");
    check("t2_drain_before_t3", sb_q.size(), 32'd0);
    push_exp(9'h040);
    wait_accept(9'h040, "t3_a40");
    drain("t3");

    // T4 redirect while the request is not accepted
    redirect_in_wait(9'h044, 32'h0000_000C, "t4_setup");
    imem_req_ready = 1'b0;
    for (int n = 0; n < 20 && !imem_req_valid; n++) cycle();
    check("t4_hold0_addr", imem_req_addr, 32'h00C);
    cycle();
    check("t4_hold1_addr", imem_req_addr, 32'h00C);
    PcSel = 1'b1;
    BrPC  = 32'h0000_0080;
    cycle();
    PcSel = 1'b0;
    check("t4_hold2_addr", imem_req_addr, 32'h00C);
    check("t4_hold2_valid", imem_req_valid, 32'd1);
    check("t4_flush_valid", IfId_Valid, 32'd0);
    imem_req_ready = 1'b1;
    wait_accept(9'h00C, "t4_aC");
    push_exp(9'h080);
    wait_accept(9'h080, "t4_a80");
    drain("t4");

    // T5 stall while the response for 0x10 arrives
    redirect_in_wait(9'h084, 32'h0000_0010, "t5_setup");
    wait_accept(9'h010, "t5_a10");
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t5_hold_pc", IfId_PC, last_exp.pc);
      check("t5_hold_instr", IfId_Instr, last_exp.instr);
      check("t5_hold_req_valid", imem_req_valid, 32'd0);
    end
    push_exp(9'h010);
    Stall = 1'b0;
    cycle();
    check("t5_release_valid", IfId_Valid, 32'd1);
    check("t5_release_pc", IfId_PC, 32'h010);
    Stall = 1'b1;
    wait_accept(9'h014, "t5_a14");
    cycle();
    check("t5_stalled_valid", IfId_Valid, 32'd1);
    check("t5_stalled_pc", IfId_PC, 32'h010);
    PcSel = 1'b1;
    BrPC  = 32'h0000_0020;
    cycle();
    PcSel = 1'b0;
    Stall = 1'b0;
    check("t5_flush_under_stall", IfId_Valid, 32'd0);
    push_exp(9'h020);
    wait_accept(9'h020, "t5_a20");
    drain("t5");

    // T6 wrap: upper bits and low bits of BrPC are ignored
    redirect_in_wait(9'h024, 32'hABCD_E1FE, "t6_setup");
    push_exp(9'h1FC);
    wait_accept(9'h1FC, "t6_a1FC");
    push_exp(9'h000);
    wait_accept(9'h000, "t6_wrap");
    drain("t6");

    // T6 reset during WAIT with a late response
    rsp_delay = 3;
    wait_accept(9'h004, "t6_a4");
    reset = 1'b0;
    #1;
    check("t6_async_req_valid", imem_req_valid, 32'd0);
    check("t6_async_ifid_valid", IfId_Valid, 32'd0);
    check("t6_async_ifid_pc", IfId_PC, 32'd0);
    check("t6_async_ifid_instr", IfId_Instr, 32'h0000_0013);
    cycle();
    cycle();
    reset = 1'b1;
    check("t6_late_rsp_pending", imem_rsp_valid, 32'd1);
    cycle();
    check("t6_late_ifid_valid", IfId_Valid, 32'd0);
    check("t6_late_ifid_instr", IfId_Instr, 32'h0000_0013);
    check("t6_restart_addr", imem_req_addr, 32'd0);
    rsp_delay = 1;
    push_exp(9'h000);
    wait_accept(9'h000, "t6_restart");
    drain("t6_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
